// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay scheduler.
package delay_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CBITS = 16;
  localparam int MAX_NREQ  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One-hot decode of a requester index. Callers narrow the result to NREQ.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [3:0] idx);
    logic [MAX_NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/delay_sched_if.sv
// Requester-side bundle of the delay scheduler: request levels, lengths, and
// the grant/done/abort/busy status returned to the requesters.
interface delay_sched_if
  import delay_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CBITS = DEF_CBITS
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  abort;
  logic                  busy;

  modport master (output req, len, input grant, done, abort, busy);
  modport slave  (input req, len, output grant, done, abort, busy);
endinterface

// File: rtl/delay_rr_arb.sv
// Combinational round-robin picker: first set req bit strictly after 'last',
// wrapping around to 0 and ending at 'last' itself.
module delay_rr_arb #(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  output logic [OW-1:0]   owner,
  output logic            valid
);

  // Two passes: indices above 'last' first, then 0..last.
  always_comb begin
    logic found;
    found = 1'b0;
    owner = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        found = 1'b1;
        owner = OW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j <= int'(last))) begin
        found = 1'b1;
        owner = OW'(j);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/delay_sched.sv
// Shared-timer scheduler: grants the single delay counter to one requester at
// a time, counts its latched length, and reports done or abort.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CBITS = DEF_CBITS
) (
  input  logic         clk,
  input  logic         rst,
  delay_sched_if.slave bus
);

  localparam int OW = $clog2(NREQ);

  state_t            state, state_n;
  logic [OW-1:0]     owner, last, pick;
  logic              pick_vld;
  logic [CBITS-1:0]  cnt, len_q;
  logic              own_req, at_end;
  logic [NREQ-1:0]   owner_oh;
  logic [NREQ-1:0]   grant, done;
  logic              abort, busy;

  delay_rr_arb #(.NREQ(NREQ), .OW(OW)) u_arb (
    .req   (bus.req),
    .last  (last),
    .owner (pick),
    .valid (pick_vld)
  );

  assign own_req  = bus.req[owner];
  assign at_end   = (cnt == len_q);
  assign owner_oh = NREQ'(onehot(4'(owner)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and outputs. done/abort are masked during reset so a reset
  // cycle never reports a completion or withdrawal.
  always_comb begin
    state_n = state;
    grant   = '0;
    done    = '0;
    abort   = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_n = RUN;
      RUN: begin
        grant = owner_oh;
        busy  = 1'b1;
        if (!own_req) begin
          abort   = !rst;
          state_n = IDLE;
        end else if (at_end) begin
          done    = rst ? '0 : owner_oh;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.grant = grant;
  assign bus.done  = done;
  assign bus.abort = abort;
  assign bus.busy  = busy;

  // Owner/pointer/length latch at grant; counter steps until it meets len_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= '0;
      last  <= OW'(NREQ - 1);
      len_q <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        owner <= pick;
        last  <= pick;
        len_q <= bus.len[pick*CBITS +: CBITS];
        cnt   <= '0;
      end
    end else begin
      if (!own_req)     cnt <= '0;
      else if (!at_end) cnt <= cnt + CBITS'(1);
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched with NREQ=4, CBITS=4.
module tb_delay_sched;

  localparam int NREQ  = 4;
  localparam int CBITS = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  delay_sched_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic a, input logic b);
    chk({tag, " grant"}, 32'(bus.grant), 32'(g));
    chk({tag, " done"},  32'(bus.done),  32'(d));
    chk({tag, " abort"}, 32'(bus.abort), 32'(a));
    chk({tag, " busy"},  32'(bus.busy),  32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [CBITS-1:0] v);
    bus.len[i*CBITS +: CBITS] = v;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.len = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.len = '0;
    tick();
    tick();
    #1;
    chk_out("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Single requester, len=3: four grant cycles, done in the last.
    do_reset();
    bus.req = 4'b0001; set_len(0, 4'd3);
    #1 chk_out("t1 c0", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      chk_out($sformatf("t1 c%0d", c), 4'b0001, (c == 4) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
    end
    tick(); bus.req = '0; #1;
    chk_out("t1 c5", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // All requesting with len=0: round-robin 0,1,2,3,0 with idle gaps.
    do_reset();
    bus.req = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      tick(); #1;
      if (c % 2 == 1)
        chk_out($sformatf("t2 c%0d", c), 4'(1 << (((c - 1) / 2) % 4)),
                4'(1 << (((c - 1) / 2) % 4)), 1'b0, 1'b1);
      else
        chk_out($sformatf("t2 c%0d", c), 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    bus.req = '0;

    // Owner withdraws at cnt=5 of len=10; pending req2 follows.
    do_reset();
    bus.req = 4'b0101; set_len(0, 4'd10); set_len(2, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      tick(); #1;
      chk_out($sformatf("t3 c%0d", c), 4'b0001, 4'b0000, 1'b0, 1'b1);
    end
    tick(); bus.req = 4'b0100; #1;
    chk_out("t3 withdraw", 4'b0001, 4'b0000, 1'b1, 1'b1);
    tick(); #1;
    chk_out("t3 idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t3 req2", 4'b0100, 4'b0100, 1'b0, 1'b1);
    bus.req = '0;

    // Maximum length 15: sixteen grant cycles, done only in the last.
    do_reset();
    bus.req = 4'b0001; set_len(0, 4'd15);
    for (int c = 1; c <= 16; c++) begin
      tick(); #1;
      chk_out($sformatf("t4 c%0d", c), 4'b0001, (c == 16) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
    end
    tick(); bus.req = '0; #1;
    chk_out("t4 c17", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset at cnt=3 of len=8, then req3+req0: req0 wins.
    do_reset();
    bus.req = 4'b0001; set_len(0, 4'd8);
    for (int c = 1; c <= 3; c++) tick();
    tick(); rst = 1'b1; #1;
    chk_out("t5 rst cyc", 4'b0001, 4'b0000, 1'b0, 1'b1);
    tick(); rst = 1'b0; bus.req = 4'b1001; set_len(0, 4'd0); set_len(3, 4'd0); #1;
    chk_out("t5 after rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); #1;
    chk_out("t5 req0 first", 4'b0001, 4'b0001, 1'b0, 1'b1);
    bus.req = '0;

    // len changes after grant: done still at the latched length 5.
    do_reset();
    bus.req = 4'b0001; set_len(0, 4'd5);
    tick(); #1;
    chk_out("t6 c1", 4'b0001, 4'b0000, 1'b0, 1'b1);
    tick(); set_len(0, 4'd1); #1;
    chk_out("t6 c2", 4'b0001, 4'b0000, 1'b0, 1'b1);
    for (int c = 3; c <= 6; c++) begin
      tick(); #1;
      chk_out($sformatf("t6 c%0d", c), 4'b0001, (c == 6) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
    end
    tick(); bus.req = '0; #1;
    chk_out("t6 c7", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset coinciding with a done condition suppresses done.
    do_reset();
    bus.req = 4'b0001; set_len(0, 4'd0);
    tick(); rst = 1'b1; #1;
    chk_out("t7 rst+done", 4'b0001, 4'b0000, 1'b0, 1'b1);
    tick(); rst = 1'b0; bus.req = '0; #1;
    chk_out("t7 after", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_sched.md
# delay_sched

Shared-timer scheduler: arbitrates up to NREQ requesters for a single CBITS-wide up-counter delay resource. A winner gets the timer, which counts its requested length and returns a one-cycle `done` pulse, then releases. Arbitration is round-robin. Sits between the control FSMs that need timed waits and the one physical delay counter, so no more than one counter instance is ever built.

## Interface

- NREQ, 4, number of requesters (2..16)
- CBITS, 16, counter and length width
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held high until `done` or voluntary withdrawal
- len  in  NREQ*CBITS  per-requester delay length; slice i = len[i*CBITS +: CBITS]; sampled only at grant
- grant  out  NREQ  one-hot (or zero), owner of the timer
- done  out  NREQ  one-hot one-cycle pulse, delay complete for owner
- abort  out  1  one-cycle pulse, owner withdrew req mid-delay
- busy  out  1  timer owned (state RUN)

## Operation

- States: IDLE, RUN. Reset → IDLE, cnt=0, grant=0, done=0, abort=0, busy=0, last=NREQ-1 (requester 0 highest priority first).
- IDLE: if any req bit set, pick first set bit scanning from (last+1) mod NREQ upward with wrap; latch owner, len_q=len slice of owner, cnt=0, last=owner; → RUN. No req → stay.
- RUN: grant[owner]=1, busy=1.
  - req[owner]=1 and cnt==len_q: done[owner]=1 this cycle; → IDLE next cycle.
  - req[owner]=1 and cnt!=len_q: cnt ← cnt+1.
  - req[owner]=0: abort=1 this cycle, no done; → IDLE, cnt ← 0. Withdrawal takes precedence over completion in the same cycle.
- Requests from non-owners in RUN are ignored (no queueing); they stay pending by holding req.
- len changes after grant have no effect; len_q is fixed for the delay.
- Arithmetic: cnt is CBITS unsigned, compared by equality to len_q before increment, so it never wraps; max len = 2^CBITS-1.
- done, abort, grant are decoded from state/registers (Moore-style relative to req sampling in previous cycle, except done/abort which also depend on current req[owner] and cnt).

## Timing

- Grant latency: req rises in cycle t while IDLE → grant high from cycle t+1.
- Delay: grant high exactly len+1 cycles; done in the last of them (cnt==len). len=0 → done in first grant cycle.
- Turnaround: at least one IDLE cycle (grant=0) between consecutive grants, even for the same requester.
- Requester must drop req in the cycle after done, or it re-competes (and round-robin places it last).
- Reset mid-RUN: next cycle IDLE, all outputs 0, no done or abort emitted, pointer back to NREQ-1.
- Simultaneous rst and done condition: rst wins; done is not asserted in the reset cycle.

## Structure

- Package delay_sched_pkg: state enum (IDLE, RUN), default NREQ/CBITS localparams, helper function for one-hot from index.
- Sub-module delay_rr_arb: combinational round-robin picker (req vector, last pointer in → owner index, valid out). delay_sched holds the pointer, FSM, counter and len_q.
- Counter is inside delay_sched, not a separate instance.

## Test plan

- Reset, then req=4'b0001, len0=3 → grant=0001 cycles 1..4, done[0] in cycle 4, grant=0 cycle 5.
- req=4'b1111 held, all len=0 → grants 0,1,2,3,0 in order, each one cycle with done, separated by one IDLE cycle.
- req0 granted with len0=10, req0 dropped at cnt=5 → abort=1 that cycle, no done, IDLE next; pending req2 granted cycle after.
- len0=2^CBITS-1 (CBITS=4: 15) → done after exactly 16 grant cycles, cnt never wraps.
- rst asserted at cnt=3 of len=8 → outputs 0 next cycle, no done/abort; after release req3 and req0 both high → req0 granted first.
- len slice changed from 5 to 1 one cycle after grant → done still at cnt=5.
